// File: rtl/hazard_controller_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
//   state_t   : FSM state encoding (IDLE=0, STALL=1, FLUSH=2)
//   MAX_STALL : upper bound for LOAD_STALL_CYCLES
//   MAX_FLUSH : upper bound for BRANCH_FLUSH_CYCLES
//   REG_W     : register-index width
package hazard_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  localparam int MAX_STALL = 3;
  localparam int MAX_FLUSH = 3;
  localparam int REG_W = 5;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID/EX hazard inputs and pipeline control outputs.
//   master : drives ID_Rs/ID_Rt/ID_UsesRs/ID_UsesRt/EX_MemRead/EX_Rd/EX_BranchTaken,
//            observes Hazard/Branch/PCWrite/IFIDWrite/IFIDFlush
//   slave  : the controller side of the same signals
//   HAZARD_STATS_EN adds StallCount/FlushCount outputs.
interface hazard_controller_if;
  import hazard_pkg::*;
  logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rd;
  logic ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken;
  logic Hazard, Branch, PCWrite, IFIDWrite, IFIDFlush;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount, FlushCount;
`endif
  modport master (
    output ID_Rs, ID_Rt, EX_Rd, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken,
    input Hazard, Branch, PCWrite, IFIDWrite, IFIDFlush
`ifdef HAZARD_STATS_EN
    , input StallCount, FlushCount
`endif
  );
  modport slave (
    input ID_Rs, ID_Rt, EX_Rd, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken,
    output Hazard, Branch, PCWrite, IFIDWrite, IFIDFlush
`ifdef HAZARD_STATS_EN
    , output StallCount, FlushCount
`endif
  );
endinterface

// File: rtl/hazard_controller_detect.sv
// hazard_detect: combinational load-use comparator.
//   i_id_rs/i_id_rt/i_uses_rs/i_uses_rt : ID-stage sources and their use flags
//   i_mem_read/i_ex_rd                  : EX-stage load flag and destination
//   o_lu                                : load-use hazard (never for r0)
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_uses_rs,
  input  logic             i_uses_rt,
  input  logic             i_mem_read,
  output logic             o_lu
);
  assign o_lu = i_mem_read && i_ex_rd != '0 &&
                ((i_uses_rs && i_id_rs == i_ex_rd) || (i_uses_rt && i_id_rt == i_ex_rd));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall and taken-branch flush control for the ID/EX register.
//   Clk, Rst (async active-low)
//   hz : hazard_controller_if.slave carrying ID/EX inputs and
//        Hazard/Branch/PCWrite/IFIDWrite/IFIDFlush outputs (Mealy)
//   Optional HAZARD_STATS_EN: StallCount/FlushCount event counters on hz.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1
) (
  input logic Clk,
  input logic Rst,
  hazard_controller_if.slave hz
);
  localparam int LS = LOAD_STALL_CYCLES > MAX_STALL ? MAX_STALL : LOAD_STALL_CYCLES;
  localparam int BF = BRANCH_FLUSH_CYCLES > MAX_FLUSH ? MAX_FLUSH : BRANCH_FLUSH_CYCLES;
  localparam logic [1:0] ST_RELOAD = 2'(LS - 1);
  localparam logic [1:0] FL_RELOAD = 2'(BF - 1);
  state_t     r_state;
  logic [1:0] r_cnt;
  logic       w_lu, w_br, w_st;
  hazard_detect u_detect (
    .i_id_rs   (hz.ID_Rs),
    .i_id_rt   (hz.ID_Rt),
    .i_ex_rd   (hz.EX_Rd),
    .i_uses_rs (hz.ID_UsesRs),
    .i_uses_rt (hz.ID_UsesRt),
    .i_mem_read(hz.EX_MemRead),
    .o_lu      (w_lu)
  );
  // A taken branch dominates everything: it squashes the stalled instruction.
  assign w_br = hz.EX_BranchTaken || r_state == FLUSH;
  assign w_st = !w_br && (r_state == STALL || (r_state == IDLE && w_lu));
  assign hz.Hazard    = Rst && w_st;
  assign hz.Branch    = Rst && w_br;
  assign hz.PCWrite   = Rst && !w_st;
  assign hz.IFIDWrite = Rst && !w_st;
  assign hz.IFIDFlush = !Rst || w_br;
  // cnt counts the cycles still owed after the current one; the FSM leaves on cnt==1.
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (hz.EX_BranchTaken) begin
      r_state <= FL_RELOAD != 2'd0 ? FLUSH : IDLE;
      r_cnt   <= FL_RELOAD;
    end else if (r_state != IDLE) begin
      r_state <= r_cnt == 2'd1 ? IDLE : r_state;
      r_cnt   <= r_cnt - 2'd1;
    end else if (w_lu && ST_RELOAD != 2'd0) begin
      r_state <= STALL;
      r_cnt   <= ST_RELOAD;
    end
`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(hz.Hazard);
      r_flush_cnt <= r_flush_cnt + 32'(hz.Branch);
    end
  assign hz.StallCount = r_stall_cnt;
  assign hz.FlushCount = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: three parameterisations driven in lockstep, checked against a remaining-cycles model.
module tb_hazard_controller;
  function automatic int lsv(int k);
    return k == 0 ? 1 : k == 1 ? 3 : 2;
  endfunction
  function automatic int bfv(int k);
    return k == 0 ? 1 : k == 1 ? 2 : 3;
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs, rt, rd;
  logic urs, urt, mr, bt;
  logic [4:0] o [3];
  logic [31:0] sc_o [3], fc_o [3];
  int total = 0, bad = 0;
  int mst [3], mfl [3];
  logic [31:0] msc [3], mfc [3];
  bit eh [3], eb [3];
  logic [4:0] last_o [3];
  logic [31:0] last_sc [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    hazard_controller_if hif ();
    assign hif.ID_Rs = rs;
    assign hif.ID_Rt = rt;
    assign hif.EX_Rd = rd;
    assign hif.ID_UsesRs = urs;
    assign hif.ID_UsesRt = urt;
    assign hif.EX_MemRead = mr;
    assign hif.EX_BranchTaken = bt;
    assign o[g] = {hif.Hazard, hif.Branch, hif.PCWrite, hif.IFIDWrite, hif.IFIDFlush};
`ifdef HAZARD_STATS_EN
    assign sc_o[g] = hif.StallCount;
    assign fc_o[g] = hif.FlushCount;
`else
    assign sc_o[g] = '0;
    assign fc_o[g] = '0;
`endif
    hazard_controller #(.LOAD_STALL_CYCLES(lsv(g)), .BRANCH_FLUSH_CYCLES(bfv(g))) dut (
      .Clk(clk),
      .Rst(rst_n),
      .hz (hif)
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [4:0] a, input logic [4:0] b, input logic ua,
                     input logic ub, input logic m, input logic [4:0] d, input logic t);
    logic lu, br, st;
    logic [4:0] exp;
    @(negedge clk);
    rst_n = r; rs = a; rt = b; urs = ua; urt = ub; mr = m; rd = d; bt = t;
    if (!r)
      for (int k = 0; k < 3; k++) begin
        mst[k] = 0; mfl[k] = 0; msc[k] = '0; mfc[k] = '0;
      end
    #1;
    lu = m && d != 0 && ((ua && a == d) || (ub && b == d));
    for (int k = 0; k < 3; k++) begin
      br = t || mfl[k] > 0;
      st = !br && (mst[k] > 0 || lu);
      exp = r ? {st, br, !st, !st, br} : 5'b00001;
      last_o[k] = o[k];
      last_sc[k] = sc_o[k];
      chk($sformatf("out%0d", k), 32'(o[k]), 32'(exp));
`ifdef HAZARD_STATS_EN
      chk($sformatf("stall_cnt%0d", k), sc_o[k], msc[k]);
      chk($sformatf("flush_cnt%0d", k), fc_o[k], mfc[k]);
`endif
      eh[k] = exp[4];
      eb[k] = exp[3];
    end
    @(posedge clk);
    if (r)
      for (int k = 0; k < 3; k++) begin
        msc[k] += 32'(eh[k]);
        mfc[k] += 32'(eb[k]);
        if (t) begin
          mfl[k] = bfv(k) - 1;
          mst[k] = 0;
        end else if (mfl[k] > 0) mfl[k]--;
        else if (mst[k] > 0) mst[k]--;
        else if (lu) mst[k] = lsv(k) - 1;
      end
  endtask
  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_out", 32'(last_o[0]), 32'h01);
    chk("reset_stats", last_sc[0], 32'h0);
    idle();
    chk("idle_out", 32'(last_o[0]), 32'h06);
    cyc(1, 5, 0, 1, 0, 1, 5, 0);
    chk("lu1_stall", 32'(last_o[0]), 32'h10);
    idle();
    chk("lu1_after", 32'(last_o[0]), 32'h06);
    chk("lu3_c2", 32'(last_o[1]), 32'h10);
    idle();
    chk("lu3_c3", 32'(last_o[1]), 32'h10);
    idle();
    chk("lu3_end", 32'(last_o[1]), 32'h06);
    cyc(1, 0, 0, 1, 1, 1, 0, 0);
    chk("r0_nostall", 32'(last_o[1]), 32'h06);
    cyc(1, 0, 5, 0, 0, 1, 5, 0);
    chk("rt_unused", 32'(last_o[1]), 32'h06);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("br_c1", 32'(last_o[1]), 32'h0f);
    idle();
    chk("br_c2", 32'(last_o[1]), 32'h0f);
    chk("br1_after", 32'(last_o[0]), 32'h06);
    idle();
    chk("br_end", 32'(last_o[1]), 32'h06);
    idle();
    cyc(1, 5, 0, 1, 0, 1, 5, 0);
    chk("abort_c1", 32'(last_o[1]), 32'h10);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("abort_br", 32'(last_o[1]), 32'h0f);
    idle();
    chk("abort_fl2", 32'(last_o[1]), 32'h0f);
    idle();
    chk("abort_done", 32'(last_o[1]), 32'h06);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_midflush", 32'(last_o[2]), 32'h01);
    idle();
    chk("post_rst", 32'(last_o[2]), 32'h06);
    chk("post_rst_stats", last_sc[2], 32'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 49) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), $urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
